// File: rtl/height_pkg.sv
// Shared types and sizing for the height history sorter.
// MAX_HOLD_EN adds one conversion slot for the running maximum.
package height_pkg;

    localparam int DEPTH   = 4;
    localparam int WIDTH   = 10;
    localparam int DIGITS  = 3;
    localparam int MAX_VAL = 999;
    localparam int BCD_W   = DIGITS * 4;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(WIDTH + 1);
`ifdef MAX_HOLD_EN
    localparam int SLOTS   = DEPTH + 1;
`else
    localparam int SLOTS   = DEPTH;
`endif
    localparam int SLOT_W  = $clog2(SLOTS);

    typedef logic [WIDTH-1:0] height_t;
    typedef logic [3:0]       bcd_digit_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SORT,
        CONV,
        HOLD
    } state_e;

    localparam height_t MAX_H = height_t'(MAX_VAL);

    function automatic height_t clamp_height(input height_t h);
        return (h > MAX_H) ? MAX_H : h;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per cycle.
// done pulses WIDTH+1 cycles after start; bcd_o holds until the next start.
module bin2bcd_seq
    import height_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BCD_W+WIDTH-1:0] sr_q;
    logic [BCD_W+WIDTH-1:0] sr_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;

    always_comb begin
        logic [BCD_W+WIDTH-1:0] tmp;
        bcd_digit_t             dig;
        tmp = sr_q;
        for (int d = 0; d < DIGITS; d++) begin
            dig = tmp[WIDTH+4*d +: 4];
            if (dig > 4'd4) begin
                tmp[WIDTH+4*d +: 4] = dig + 4'd3;
            end
        end
        sr_d = {tmp[BCD_W+WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            sr_q   <= {{BCD_W{1'b0}}, bin_i};
            cnt_q  <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                sr_q  <= sr_d;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign bcd_o  = sr_q[WIDTH +: BCD_W];

endmodule

// File: rtl/height_history_sorter.sv
// Keeps recent heights, sorts them largest-first, converts to BCD, publishes at frame_start.
// MAX_HOLD_EN adds max_bcd/max_vld tracking the largest clamped height since reset.
module height_history_sorter
    import height_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       height_in,
    input  logic                   height_valid,
    input  logic                   frame_start,
    output logic [DEPTH*BCD_W-1:0] recent_bcd,
    output logic [DEPTH*BCD_W-1:0] sorted_bcd,
    output logic [DEPTH-1:0]       recent_vld,
    output logic [DEPTH-1:0]       sorted_vld,
    output logic                   busy,
`ifdef MAX_HOLD_EN
    output logic [BCD_W-1:0]       max_bcd,
    output logic                   max_vld,
`endif
    output logic                   overflow
);

    state_e                        state_q;
    height_t                       pend_q;
    logic                          pend_full_q;
    logic                          ovf_q;
    logic [DEPTH-1:0][WIDTH-1:0]   hist_q;
    logic [DEPTH-1:0]              vld_q;
    logic [DEPTH-1:0][IDX_W-1:0]   idx_q;
    logic [DEPTH-1:0][IDX_W-1:0]   idx_d;
    logic [IDX_W-1:0]              pass_q;
    logic [SLOT_W-1:0]             slot_q;
    logic [SLOT_W-1:0]             nslot;
    logic [DEPTH-1:0][BCD_W-1:0]   shadow_q;
    logic [DEPTH-1:0][BCD_W-1:0]   rbcd_q;
    logic [DEPTH-1:0][BCD_W-1:0]   sbcd_q;
    logic [DEPTH-1:0]              rvld_q;
    logic [DEPTH-1:0]              svld_q;
    height_t                       pend_clamped;
    height_t                       conv_bin;
    logic                          conv_start;
    logic                          conv_done;
    logic                          conv_busy;
    logic [BCD_W-1:0]              conv_bcd;
    logic                          last_pass;
    logic                          last_slot;
`ifdef MAX_HOLD_EN
    height_t                       max_q;
    logic                          max_seen_q;
    logic [BCD_W-1:0]              max_shadow_q;
    logic [BCD_W-1:0]              max_bcd_q;
    logic                          max_vld_q;
`endif

    assign pend_clamped = clamp_height(pend_q);
    assign last_pass    = (pass_q == IDX_W'(DEPTH - 1));
    assign last_slot    = (slot_q == SLOT_W'(SLOTS - 1));

    // Next conversion starts on the final sort pass, then chains on each done.
    assign conv_start = (state_q == SORT && last_pass)
                     || (state_q == CONV && conv_done && !last_slot);
    assign nslot      = (state_q == CONV) ? slot_q + 1'b1 : '0;

    always_comb begin
`ifdef MAX_HOLD_EN
        conv_bin = hist_q[nslot[IDX_W-1:0]];
        if (nslot == SLOT_W'(DEPTH)) begin
            conv_bin = max_q;
        end
`else
        conv_bin = hist_q[nslot];
`endif
    end

    // One odd-even transposition pass; strict compare keeps equal keys stable.
    always_comb begin
        idx_d = idx_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i[0] == pass_q[0]) begin
                if ({vld_q[idx_q[i+1]], hist_q[idx_q[i+1]]} >
                    {vld_q[idx_q[i]],   hist_q[idx_q[i]]}) begin
                    idx_d[i]   = idx_q[i+1];
                    idx_d[i+1] = idx_q[i];
                end
            end
        end
    end

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            hist_q      <= '0;
            vld_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            slot_q      <= '0;
            shadow_q    <= '0;
            rbcd_q      <= '0;
            sbcd_q      <= '0;
            rvld_q      <= '0;
            svld_q      <= '0;
`ifdef MAX_HOLD_EN
            max_q        <= '0;
            max_seen_q   <= 1'b0;
            max_shadow_q <= '0;
            max_bcd_q    <= '0;
            max_vld_q    <= 1'b0;
`endif
        end else begin
            ovf_q <= height_valid && pend_full_q && (state_q != SHIFT);
            if (height_valid) begin
                pend_q      <= height_in;
                pend_full_q <= 1'b1;
            end else if (state_q == SHIFT) begin
                pend_full_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (pend_full_q) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    hist_q <= {hist_q[DEPTH-2:0], pend_clamped};
                    vld_q  <= {vld_q[DEPTH-2:0], 1'b1};
                    for (int i = 0; i < DEPTH; i++) begin
                        idx_q[i] <= IDX_W'(i);
                    end
                    pass_q <= '0;
`ifdef MAX_HOLD_EN
                    if (pend_clamped > max_q) begin
                        max_q <= pend_clamped;
                    end
                    max_seen_q <= 1'b1;
`endif
                    state_q <= SORT;
                end
                SORT: begin
                    idx_q  <= idx_d;
                    pass_q <= pass_q + 1'b1;
                    if (last_pass) begin
                        slot_q  <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    if (conv_done) begin
`ifdef MAX_HOLD_EN
                        if (slot_q == SLOT_W'(DEPTH)) begin
                            max_shadow_q <= conv_bcd;
                        end else begin
                            shadow_q[slot_q[IDX_W-1:0]] <= conv_bcd;
                        end
`else
                        shadow_q[slot_q] <= conv_bcd;
`endif
                        if (last_slot) begin
                            state_q <= HOLD;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (frame_start) begin
                        rbcd_q <= shadow_q;
                        rvld_q <= vld_q;
                        for (int k = 0; k < DEPTH; k++) begin
                            sbcd_q[k] <= shadow_q[idx_q[k]];
                            svld_q[k] <= vld_q[idx_q[k]];
                        end
`ifdef MAX_HOLD_EN
                        max_bcd_q <= max_shadow_q;
                        max_vld_q <= max_seen_q;
`endif
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign recent_bcd = rbcd_q;
    assign sorted_bcd = sbcd_q;
    assign recent_vld = rvld_q;
    assign sorted_vld = svld_q;
    assign busy       = (state_q != IDLE) || conv_busy;
    assign overflow   = ovf_q;
`ifdef MAX_HOLD_EN
    assign max_bcd    = max_bcd_q;
    assign max_vld    = max_vld_q;
`endif

endmodule
